fsm_input_conditioner: RTL and testbench
========================================

# fsm_input_conditioner

Input conditioning stage directly upstream of the FSM core in the tt_um_fsm_dgarciag44 tile. Takes raw asynchronous button/switch levels from `ui_in`, then synchronises, debounces and edge-detects them. It hands the FSM clean, stable levels and single-cycle event pulses. The top level drives `rst` from `~rst_n`.

## Interface
- `WIDTH`, 4: number of independent input channels (1..8).
- `DEBOUNCE_CYCLES`, 16: consecutive cycles a synchronised input must differ from the stable level before the change is accepted (>= 1).
- `clk`  in  1  tile clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en_i`  in  1  conditioning enable (tied to `ena`).
- `raw_i`  in  WIDTH  raw asynchronous inputs.
- `level_o`  out  WIDTH  debounced stable level per channel.
- `rise_o`  out  WIDTH  one-cycle pulse when `level_o[k]` goes 0→1.
- `fall_o`  out  WIDTH  one-cycle pulse when `level_o[k]` goes 1→0 (see Configuration).
- `event_o`  out  1  OR of all `rise_o` and `fall_o` bits, registered in the same cycle as the pulses.

## Operation
- Per channel k:
  - 2-flop synchroniser produces `sync[k]`.
  - Counter `cnt[k]` has width `$clog2(DEBOUNCE_CYCLES+1)`.
  - Stable register `level_o[k]`.
- Each edge with `en_i`=1:
  - If `sync[k]` == `level_o[k]`: `cnt[k]` <= 0. A glitch shorter than the window is rejected and the count restarts.
  - Else if `cnt[k]` == `DEBOUNCE_CYCLES-1`: `level_o[k]` <= `sync[k]`, `cnt[k]` <= 0, and the matching `rise_o[k]` or `fall_o[k]` <= 1.
  - Else: `cnt[k]` <= `cnt[k]`+1.
- Pulse bits are registered and default to 0 every cycle, so they are high for exactly one cycle per accepted transition.
- `event_o` is registered with the pulses.
- When `en_i`=0:
  - Synchroniser keeps sampling.
  - All counters are forced to 0.
  - `level_o` holds.
  - All pulses are 0.
  - On re-enable, a differing input needs a full new window.
- Channels are fully independent. Simultaneous transitions on several channels produce simultaneous pulses, and `event_o` is a single 1 for that cycle.
- The counter never exceeds `DEBOUNCE_CYCLES-1`, so no wrap-around is possible.

## Timing
- Reset values: `level_o`=0, `rise_o`=0, `fall_o`=0, `event_o`=0; synchroniser flops and counters are also 0.
- Clean input step before edge E:
  - `sync` changes after edge E+1.
  - `level_o` and the pulse change after edge E+1+`DEBOUNCE_CYCLES`.
  - Total latency is `DEBOUNCE_CYCLES`+2 cycles.
- `level_o` changes and its pulse asserts at the same edge. The FSM consumes the pulse on the following edge.
- With `DEBOUNCE_CYCLES`=1 the latency is 3 cycles, and an input must differ for 1 sampled cycle to be accepted.
- Reset asserted mid-window clears state immediately (asynchronously). A pulse in flight is dropped.
- Reset deassertion is synchronised externally by the tile and is not the block's responsibility.

## Configuration
- Macro `FSM_IN_FALL_EDGE_EN`.
- Defined: falling-edge detection is built, `fall_o` behaves as above, and `event_o` includes falls.
- Undefined:
  - No fall-pulse flops are generated.
  - `fall_o` is constant 0.
  - `event_o` reflects rises only.
  - `level_o` still tracks both directions.

## Structure
- Shared package `fsm_pkg` holds:
  - `FSM_IN_WIDTH` (4), the default for `WIDTH`.
  - `FSM_DEBOUNCE_CYCLES` (16), the default for `DEBOUNCE_CYCLES`.
  - The `ui_in` bit-index constants mapping buttons to channels, used by the FSM core.
- One sub-module, `fsm_in_debounce_ch`, covers one channel: synchroniser, counter, stable level and pulse flops.
- `fsm_input_conditioner` instantiates `WIDTH` copies via generate and forms `event_o`.

## Test plan
All scenarios use `WIDTH`=4 and `DEBOUNCE_CYCLES`=4.
1. Reset check:
   - Assert `rst` with `raw_i`=4'hF.
   - Required: all outputs 0 during reset.
   - Release `rst` and hold `raw_i`=4'hF.
   - Required: `level_o`=4'hF exactly 6 cycles after the first post-reset edge, with `rise_o`=4'hF and `event_o`=1 for one cycle.
2. Glitch rejection:
   - Drive `raw_i[0]` high for 3 cycles, then low.
   - Required: `level_o[0]` stays 0, no pulses.
   - Drive it high for 4+ cycles.
   - Required: exactly one `rise_o[0]` pulse.
3. Fall and configuration:
   - With `level_o[2]`=1, drop `raw_i[2]` to 0.
   - Required with `FSM_IN_FALL_EDGE_EN`: one `fall_o[2]` pulse after 6 cycles, and `event_o`=1.
   - Required without the macro: `fall_o`=0, `event_o` stays 0, `level_o[2]` still goes 0.
4. Simultaneous transitions:
   - Raise channels 1 and 3 on the same cycle.
   - Required: `rise_o`=4'b1010 for one cycle and `event_o`=1 for one cycle.
5. Enable gating:
   - Raise `raw_i[0]` and drop `en_i` after 2 counting cycles for 5 cycles, then restore `en_i`.
   - Required: no pulse while disabled; `rise_o[0]` exactly 4 cycles after `en_i` returns to 1.
6. Reset mid-window:
   - Assert `rst` with `cnt[1]`=3 pending.
   - Required: no pulse, `level_o`=0 immediately, and counting restarts from 0 after release.

Source files
------------

// File: rtl/fsm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fsm_pkg
// Brief    : Shared constants for the FSM tile: input-conditioner defaults
//            and the ui_in bit positions of the buttons/switches.
// Revision : 1.0 - initial release
// ============================================================================
package fsm_pkg;

    localparam int FSM_IN_WIDTH        = 4;
    localparam int FSM_DEBOUNCE_CYCLES = 16;

    // ui_in bit positions; each one is also the conditioner channel index
    typedef enum logic [2:0] {
        UI_BTN_START = 3'd0,
        UI_BTN_STOP  = 3'd1,
        UI_BTN_MODE  = 3'd2,
        UI_SW_DIR    = 3'd3
    } fsm_ui_bit_e;

    function automatic int fsm_cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fsm_in_debounce_ch.sv
`default_nettype none
// ============================================================================
// Module   : fsm_in_debounce_ch
// Brief    : One conditioning channel: 2-flop synchroniser, debounce counter,
//            stable level and edge pulses. Fall pulses only if
//            FSM_IN_FALL_EDGE_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module fsm_in_debounce_ch
    import fsm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = FSM_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic rise_next_o,
    output logic fall_next_o
);

    localparam int              c_cnt_w    = fsm_cnt_width(DEBOUNCE_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    logic               r_meta;
    logic               r_sync;
    logic               r_level;
    logic               r_rise;
    logic [c_cnt_w-1:0] r_cnt;

    logic w_differs;
    logic w_accept;
    logic w_rise_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= raw_i;
            r_sync <= r_meta;
        end
    end

    assign w_differs   = (r_sync != r_level);
    assign w_accept    = en_i && w_differs && (r_cnt == c_cnt_last);
    assign w_rise_next = w_accept && r_sync;

    // Any agreeing sample, disable or acceptance restarts the window
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
        end else begin
            if (!en_i || !w_differs || w_accept) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + c_cnt_w'(1);
            end
            if (w_accept) begin
                r_level <= r_sync;
            end
            r_rise <= w_rise_next;
        end
    end

    assign level_o     = r_level;
    assign rise_o      = r_rise;
    assign rise_next_o = w_rise_next;

`ifdef FSM_IN_FALL_EDGE_EN
    logic r_fall;
    logic w_fall_next;

    assign w_fall_next = w_accept && !r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fall <= 1'b0;
        end else begin
            r_fall <= w_fall_next;
        end
    end

    assign fall_o      = r_fall;
    assign fall_next_o = w_fall_next;
`else
    assign fall_o      = 1'b0;
    assign fall_next_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/fsm_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : fsm_input_conditioner
// Brief    : WIDTH independent debounce channels plus a registered event flag
//            aligned with the pulses. FSM_IN_FALL_EDGE_EN enables fall pulses.
// Revision : 1.0 - initial release
// ============================================================================
module fsm_input_conditioner
    import fsm_pkg::*;
#(
    parameter int WIDTH           = FSM_IN_WIDTH,
    parameter int DEBOUNCE_CYCLES = FSM_DEBOUNCE_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic [WIDTH-1:0] raw_i,
    output logic [WIDTH-1:0] level_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    output logic             event_o
);

    logic [WIDTH-1:0] w_rise_next;
    logic [WIDTH-1:0] w_fall_next;
    logic             r_event;

    generate
        for (genvar k = 0; k < WIDTH; k++) begin : g_ch
            fsm_in_debounce_ch #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_ch (
                .clk         (clk),
                .rst         (rst),
                .en_i        (en_i),
                .raw_i       (raw_i[k]),
                .level_o     (level_o[k]),
                .rise_o      (rise_o[k]),
                .fall_o      (fall_o[k]),
                .rise_next_o (w_rise_next[k]),
                .fall_next_o (w_fall_next[k])
            );
        end
    endgenerate

    // Built from the same next-state terms as the pulse flops so it lands with them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_event <= 1'b0;
        end else begin
            r_event <= (|w_rise_next) | (|w_fall_next);
        end
    end

    assign event_o = r_event;

endmodule
`default_nettype wire

// File: tb/tb_fsm_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_fsm_input_conditioner
// Brief    : Directed vector table plus hand-written reset sequences for
//            fsm_input_conditioner (WIDTH=4, DEBOUNCE_CYCLES=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fsm_input_conditioner;

`ifdef FSM_IN_FALL_EDGE_EN
    localparam bit c_fall_built = 1'b1;
`else
    localparam bit c_fall_built = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       en_i;
    logic [3:0] raw_i;
    logic [3:0] level_o;
    logic [3:0] rise_o;
    logic [3:0] fall_o;
    logic       event_o;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic       rst;
        logic       en;
        logic [3:0] raw;
        logic [3:0] level;
        logic [3:0] rise;
        logic [3:0] fall;
    } vec_t;

    vec_t vecs[$];

    fsm_input_conditioner #(
        .WIDTH           (4),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en_i    (en_i),
        .raw_i   (raw_i),
        .level_o (level_o),
        .rise_o  (rise_o),
        .fall_o  (fall_o),
        .event_o (event_o)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic e, input logic [3:0] raw,
                       input logic [3:0] lvl, input logic [3:0] rise,
                       input logic [3:0] fall);
        vec_t v;
        v.rst = r; v.en = e; v.raw = raw;
        v.level = lvl; v.rise = rise; v.fall = fall;
        vecs.push_back(v);
    endtask

    // Clean step held from edge 1: level and pulse appear on edge 6 (4 + 2)
    task automatic add_window(input logic [3:0] raw, input logic [3:0] from,
                              input logic [3:0] to);
        for (int i = 0; i < 5; i++) add(1'b0, 1'b1, raw, from, 4'h0, 4'h0);
        add(1'b0, 1'b1, raw, to, to & ~from, from & ~to);
        add(1'b0, 1'b1, raw, to, 4'h0, 4'h0);
    endtask

    task automatic check(input string name, input logic [3:0] el,
                         input logic [3:0] er, input logic [3:0] ef);
        logic [3:0] ef_eff;
        logic       ee;
        ef_eff = c_fall_built ? ef : 4'h0;
        ee     = (er != 4'h0) || (ef_eff != 4'h0);
        n_vec++;
        if (level_o !== el || rise_o !== er || fall_o !== ef_eff || event_o !== ee) begin
            n_bad++;
            $display("FAIL %s: got level=%h rise=%h fall=%h event=%b, want level=%h rise=%h fall=%h event=%b",
                     name, level_o, rise_o, fall_o, event_o, el, er, ef_eff, ee);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic [3:0] raw);
        @(negedge clk);
        rst = r; en_i = e; raw_i = raw;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; en_i = 1'b1; raw_i = 4'hF;
        #1;
        check("reset_async", 4'h0, 4'h0, 4'h0);

        // reset held with raw high, then released: all four rise together
        add(1'b1, 1'b1, 4'hF, 4'h0, 4'h0, 4'h0);
        add(1'b1, 1'b1, 4'hF, 4'h0, 4'h0, 4'h0);
        add_window(4'hF, 4'h0, 4'hF);
        // channel 2 falls alone
        add_window(4'hB, 4'hF, 4'hB);
        // remaining channels fall together
        add_window(4'h0, 4'hB, 4'h0);
        // 3-cycle glitch on channel 0 is rejected
        for (int i = 0; i < 3; i++) add(1'b0, 1'b1, 4'h1, 4'h0, 4'h0, 4'h0);
        for (int i = 0; i < 5; i++) add(1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0);
        // sustained high is accepted once
        add_window(4'h1, 4'h0, 4'h1);
        // channels 1 and 3 rise on the same edge
        add_window(4'hB, 4'h1, 4'hB);
        add_window(4'h0, 4'hB, 4'h0);
        // enable gating: 2 counting edges, 5 disabled, then a full new window
        for (int i = 0; i < 4; i++) add(1'b0, 1'b1, 4'h1, 4'h0, 4'h0, 4'h0);
        for (int i = 0; i < 5; i++) add(1'b0, 1'b0, 4'h1, 4'h0, 4'h0, 4'h0);
        for (int i = 0; i < 3; i++) add(1'b0, 1'b1, 4'h1, 4'h0, 4'h0, 4'h0);
        add(1'b0, 1'b1, 4'h1, 4'h1, 4'h1, 4'h0);
        add(1'b0, 1'b1, 4'h1, 4'h1, 4'h0, 4'h0);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].en, vecs[i].raw);
            check($sformatf("vec%0d", i), vecs[i].level, vecs[i].rise, vecs[i].fall);
        end

        // reset while channel 1 has cnt=3 pending
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 4'h3);
            check($sformatf("pend%0d", i), 4'h1, 4'h0, 4'h0);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid_async", 4'h0, 4'h0, 4'h0);
        @(posedge clk);
        #1;
        check("rst_mid_edge", 4'h0, 4'h0, 4'h0);
        for (int i = 1; i <= 7; i++) begin
            step(1'b0, 1'b1, 4'h3);
            if (i < 6)       check($sformatf("restart%0d", i), 4'h0, 4'h0, 4'h0);
            else if (i == 6) check("restart_accept", 4'h3, 4'h3, 4'h0);
            else             check("restart_after", 4'h3, 4'h0, 4'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
